alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; legal values are even and 8..32.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), the number of bits in a shift amount.
REQ-003 SHALL have port Clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nReset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Start  input  1  operation request, sampled at the rising edge.
REQ-006 SHALL have port Func  input  5  function code.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount k.
REQ-009 SHALL have port Busy  output  1  a multi-cycle operation is in progress.
REQ-010 SHALL have port Done  output  1  one-cycle pulse; Result and Flags are valid.
REQ-011 SHALL have port Result  output  WIDTH  registered result.
REQ-012 SHALL have port Flags  output  4  registered flags; bit0 Z, bit1 C, bit2 V, bit3 N.

Function
REQ-013 SHALL decode function codes FnA=0, FnB=1, FnADD=2, FnADC=3, FnSUB=4, FnSUC=5, FnNEG=6, FnAND=7, FnOR=8, FnXOR=9, FnNOT=10, FnNAND=11, FnNOR=12, FnLSL=13, FnLSR=14, FnASR=15, FnLUI=16, FnLLI=17, FnMUL=18.
REQ-014 SHALL implement states IDLE, SHIFT and MUL; Busy is high exactly when the state is SHIFT or MUL.
REQ-015 SHALL accept Start only in IDLE; Start while Busy is ignored; Start in a Done cycle is accepted.
REQ-016 SHALL number cycles from the cycle in which Start is sampled (cycle 0), and assert Done in cycle L for exactly one cycle.
REQ-017 SHALL use L=1 for all non-shift functions and for shifts with k=0; L=k+1 for shifts with k>=1; L=WIDTH+1 for FnMUL.
REQ-018 SHALL latch A, B, Func and k at Start; operand changes after cycle 0 have no effect on the operation.
REQ-019 SHALL compute arithmetic modulo 2^WIDTH: ADD A+B; ADC A+B+C; SUB A+~B+1; SUC A+~B+C; NEG ~A+1. C is the stored flag and C=1 means no borrow.
REQ-020 SHALL compute logic functions bitwise: NOT gives ~A; FnA gives A; FnB gives B.
REQ-021 SHALL compute LUI as {B[WIDTH/2-1:0], A[WIDTH/2-1:0]} and LLI as {A[WIDTH-1:WIDTH/2], B[WIDTH/2-1:0]}.
REQ-022 SHALL implement shifts iteratively, one bit per cycle, in the SHIFT state using a down-counter of width SHW.
REQ-023 SHALL shift in 0 for LSL and LSR, and replicate the MSB for ASR.
REQ-024 SHALL update Result and Flags only on the edge that raises Done; both hold their value otherwise.
REQ-025 SHALL set Z=(Result==0) and N=Result[WIDTH-1] for every function.
REQ-026 SHALL set C to the adder carry-out and V to signed overflow for ADD, ADC, SUB, SUC and NEG.
REQ-027 SHALL clear C and V for logic functions, FnA, FnB, LUI and LLI.
REQ-028 SHALL set C to the last bit shifted out (C=0 when k=0) and V=0 for shifts.
REQ-029 SHALL treat codes 19..31 as undefined: Result=A, Flags unchanged, L=1.

Reset
REQ-030 SHALL, while nReset=0, immediately force state IDLE, Busy=0, Done=0, Result=0, Flags=0 and counter=0, regardless of the current state.
REQ-031 SHALL abandon an operation in progress when reset is asserted mid-operation, without producing a Done.
REQ-032 SHALL accept Start from the first rising edge after nReset deasserts.

Configuration
REQ-033 SHALL compile FnMUL in only when macro ALU_MUL_EN is defined.
REQ-034 SHALL, with ALU_MUL_EN defined, implement FnMUL as an iterative shift-add over WIDTH cycles in state MUL.
REQ-035 SHALL, with ALU_MUL_EN defined, give FnMUL Result = low WIDTH bits of A*B (unsigned), C=1 if the high WIDTH bits are nonzero, and V=0.
REQ-036 SHALL, without ALU_MUL_EN, contain no MUL state or logic and treat code 18 per REQ-029.

Verification (WIDTH=16)
REQ-037 SHALL test FnADD with A=0x7FFF, B=0x0001 -> Done in cycle 1, Result=0x8000, Flags=0xC.
REQ-038 SHALL test FnADD with A=0xFFFF, B=0x0001 -> Result=0x0000, Flags=0x3; then FnADC with A=0x0001, B=0x0001 -> Result=0x0003, Flags=0x0.
REQ-039 SHALL test FnSUB with A=0x0005, B=0x0005 -> Result=0x0000, Flags=0x3.
REQ-040 SHALL test FnASR with A=0x8004, B=3, plus a Start in cycle 2 -> Busy high in cycles 1..3, Done in cycle 4, Result=0xF000, Flags=0xA, the second Start ignored.
REQ-041 SHALL test FnLSL with k=15 and nReset pulsed low in cycle 5 -> Busy=Done=0, Result=0, Flags=0 immediately; a following FnA Start completes in cycle 1.
REQ-042 SHALL test, with ALU_MUL_EN defined, FnMUL with A=0x0100, B=0x0100 -> Done in cycle 17, Result=0x0000, Flags=0x3; without ALU_MUL_EN, code 18 gives Result=A in cycle 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle arithmetic and logic, iterative
// one-bit-per-cycle shifts, and an optional iterative shift-add multiplier.
//
// Ports:
//   Clock   - single clock, all state changes on its rising edge
//   nReset  - asynchronous active-low reset
//   Start   - operation request, accepted only while idle
//   Func    - 5-bit function code
//   A, B    - operands; B[SHW-1:0] is the shift amount for shifts
//   Busy    - a multi-cycle (shift or multiply) operation is in progress
//   Done    - one-cycle pulse, Result and Flags are valid
//   Result  - registered result
//   Flags   - registered flags {N, V, C, Z}
//
// Optional feature: define ALU_MUL_EN to build in FnMUL (code 18). Without
// it, code 18 is an undefined code (Result = A, Flags unchanged).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic [4:0]       Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags
);

  localparam int HALF = WIDTH / 2;

  localparam logic [4:0] FN_A    = 5'd0;
  localparam logic [4:0] FN_B    = 5'd1;
  localparam logic [4:0] FN_ADD  = 5'd2;
  localparam logic [4:0] FN_ADC  = 5'd3;
  localparam logic [4:0] FN_SUB  = 5'd4;
  localparam logic [4:0] FN_SUC  = 5'd5;
  localparam logic [4:0] FN_NEG  = 5'd6;
  localparam logic [4:0] FN_AND  = 5'd7;
  localparam logic [4:0] FN_OR   = 5'd8;
  localparam logic [4:0] FN_XOR  = 5'd9;
  localparam logic [4:0] FN_NOT  = 5'd10;
  localparam logic [4:0] FN_NAND = 5'd11;
  localparam logic [4:0] FN_NOR  = 5'd12;
  localparam logic [4:0] FN_LSL  = 5'd13;
  localparam logic [4:0] FN_LSR  = 5'd14;
  localparam logic [4:0] FN_ASR  = 5'd15;
  localparam logic [4:0] FN_LUI  = 5'd16;
  localparam logic [4:0] FN_LLI  = 5'd17;
`ifdef ALU_MUL_EN
  localparam logic [4:0] FN_MUL  = 5'd18;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef ALU_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  // Flags are packed {N, V, C, Z}; Z and N always follow the result.
  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
    return {res[WIDTH-1], v, c, (res == {WIDTH{1'b0}})};
  endfunction

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [SHW-1:0]   r_cnt;
  logic [4:0]       r_func;
  logic [WIDTH-1:0] r_sh;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic             w_mul;
`endif

  logic [WIDTH-1:0] w_add_x;
  logic [WIDTH-1:0] w_add_y;
  logic             w_add_ci;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_undef;
  logic             w_shift;
  logic [SHW-1:0]   w_k;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_out;

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;
  assign Flags  = r_flags;
  assign w_k    = B[SHW-1:0];

  // Adder operand selection: subtraction and negation reuse one adder via inversion.
  always_comb begin
    w_add_x  = A;
    w_add_y  = B;
    w_add_ci = 1'b0;
    case (Func)
      FN_ADC:  w_add_ci = r_flags[1];
      FN_SUB:  begin w_add_y = ~B; w_add_ci = 1'b1; end
      FN_SUC:  begin w_add_y = ~B; w_add_ci = r_flags[1]; end
      FN_NEG:  begin w_add_x = ~A; w_add_y = {WIDTH{1'b0}}; w_add_ci = 1'b1; end
      default: w_add_ci = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_ci};
  // Signed overflow: operands agree in sign but the sum does not.
  assign w_ovf = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != w_add_x[WIDTH-1]);

  // Single-cycle result and flag selection; shifts report A with C=0 for k=0.
  always_comb begin
    w_res   = A;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_undef = 1'b0;
    w_shift = 1'b0;
`ifdef ALU_MUL_EN
    w_mul   = 1'b0;
`endif
    case (Func)
      FN_A:    w_res = A;
      FN_B:    w_res = B;
      FN_ADD, FN_ADC, FN_SUB, FN_SUC, FN_NEG: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      FN_AND:  w_res = A & B;
      FN_OR:   w_res = A | B;
      FN_XOR:  w_res = A ^ B;
      FN_NOT:  w_res = ~A;
      FN_NAND: w_res = ~(A & B);
      FN_NOR:  w_res = ~(A | B);
      FN_LSL, FN_LSR, FN_ASR: w_shift = 1'b1;
      FN_LUI:  w_res = {B[HALF-1:0], A[HALF-1:0]};
      FN_LLI:  w_res = {A[WIDTH-1:HALF], B[HALF-1:0]};
`ifdef ALU_MUL_EN
      FN_MUL:  w_mul = 1'b1;
`endif
      default: w_undef = 1'b1;
    endcase
  end

  // One shift step on the working register; w_sh_out is the bit leaving it.
  always_comb begin
    w_sh_next = r_sh;
    w_sh_out  = 1'b0;
    case (r_func)
      FN_LSL:  {w_sh_out, w_sh_next} = {r_sh, 1'b0};
      FN_LSR:  begin w_sh_next = {1'b0, r_sh[WIDTH-1:1]}; w_sh_out = r_sh[0]; end
      FN_ASR:  begin w_sh_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]}; w_sh_out = r_sh[0]; end
      default: w_sh_out = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-add step: add the multiplicand when the multiplier LSB is set, then
  // shift the {hi, lo} product pair right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
  assign w_hi_next = w_mul_sum[WIDTH:1];
  assign w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`endif

  // Control FSM with registered Busy/Done/Result/Flags.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {WIDTH{1'b0}};
      r_flags  <= 4'h0;
      r_cnt    <= {SHW{1'b0}};
      r_func   <= 5'd0;
      r_sh     <= {WIDTH{1'b0}};
`ifdef ALU_MUL_EN
      r_opa    <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_func <= Func;
            if (w_shift && (w_k != {SHW{1'b0}})) begin
              r_sh    <= A;
              r_cnt   <= w_k;
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
`ifdef ALU_MUL_EN
            end else if (w_mul) begin
              r_opa   <= A;
              r_hi    <= {WIDTH{1'b0}};
              r_lo    <= B;
              r_cnt   <= SHW'(WIDTH - 1);
              r_busy  <= 1'b1;
              r_state <= S_MUL;
`endif
            end else begin
              r_result <= w_res;
              r_done   <= 1'b1;
              // Undefined codes pass A through but leave the flags alone.
              if (!w_undef) begin
                r_flags <= make_flags(w_res, w_c, w_v);
              end else begin
                r_flags <= r_flags;
              end
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt - SHW'(1);
          // Counter value 1 means this edge performs the final shift.
          if (r_cnt == SHW'(1)) begin
            r_result <= w_sh_next;
            r_flags  <= make_flags(w_sh_next, w_sh_out, 1'b0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == {SHW{1'b0}}) begin
            r_result <= w_lo_next;
            r_flags  <= make_flags(w_lo_next, (w_hi_next != {WIDTH{1'b0}}), 1'b0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_state <= S_MUL;
          end
        end
`endif
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed cases from the
// requirements followed by randomized operations against an arithmetic model.
module tb_alu_seq;

  localparam int W = 16;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          Start = 1'b0;
  logic [4:0]    Func = 5'd0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  Result;
  logic [3:0]    Flags;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_result = '0;
  logic [3:0]   m_flags  = 4'h0;

  alu_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Func(Func),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result), .Flags(Flags)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ovf(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Reference: plain integer arithmetic on the documented rules.
  function automatic void ref_model(input logic [4:0] f, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [3:0] fl,
                                    output logic [W-1:0] r, output logic [3:0] fo,
                                    output int lat);
    longint ua, ub, full, sa, sb, cin;
    int k;
    logic cc, vv, undef;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = longint'(fl[1]);
    k = int'(b[3:0]);
    cc = 1'b0; vv = 1'b0; undef = 1'b0; lat = 1; full = ua;
    case (f)
      5'd0:  full = ua;
      5'd1:  full = ub;
      5'd2:  begin full = ua + ub; cc = full > 65535; vv = ovf(sa + sb); end
      5'd3:  begin full = ua + ub + cin; cc = full > 65535; vv = ovf(sa + sb + cin); end
      5'd4:  begin full = ua - ub; cc = full >= 0; vv = ovf(sa - sb); end
      5'd5:  begin full = ua - ub - (1 - cin); cc = full >= 0; vv = ovf(sa - sb - (1 - cin)); end
      5'd6:  begin full = -ua; cc = (ua == 0); vv = ovf(-sa); end
      5'd7:  full = ua & ub;
      5'd8:  full = ua | ub;
      5'd9:  full = ua ^ ub;
      5'd10: full = ~ua;
      5'd11: full = ~(ua & ub);
      5'd12: full = ~(ua | ub);
      5'd13: begin full = ua << k; cc = (k != 0) && (((ua >> (W - k)) & 1) != 0);
                   lat = (k != 0) ? k + 1 : 1; end
      5'd14: begin full = ua >> k; cc = (k != 0) && (((ua >> (k - 1)) & 1) != 0);
                   lat = (k != 0) ? k + 1 : 1; end
      5'd15: begin full = sa >>> k; cc = (k != 0) && (((ua >> (k - 1)) & 1) != 0);
                   lat = (k != 0) ? k + 1 : 1; end
      5'd16: full = (ub % 256) * 256 + (ua % 256);
      5'd17: full = (ua / 256) * 256 + (ub % 256);
`ifdef ALU_MUL_EN
      5'd18: begin full = ua * ub; cc = (full / 65536) != 0; lat = W + 1; end
`endif
      default: undef = 1'b1;
    endcase
    r = W'(full);
    if (undef) fo = fl;
    else       fo = {r[W-1], vv, cc, (r == 0)};
  endfunction

  // Issue one operation starting in the current cycle and follow it to Done.
  task automatic run_op(input logic [4:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int got_lat);
    logic [W-1:0] er;
    logic [3:0]   ef;
    int lat, cyc;
    ref_model(f, a, b, m_flags, er, ef, lat);
    Func = f; A = a; B = b; Start = 1'b1;
    @(negedge Clock);
    cyc = 1;
    while (!Done && cyc < 64) begin
      check("busy_mid", Busy, 1'b1);
      check("hold_result", Result, m_result);
      check("hold_flags", Flags, m_flags);
      // Requests while busy, including one in cycle 2, must be ignored.
      Start = (cyc == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      Func  = 5'($urandom); A = W'($urandom); B = W'($urandom);
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    Func  = 5'($urandom); A = W'($urandom); B = W'($urandom);
    check("latency", cyc, lat);
    check("busy_at_done", Busy, 1'b0);
    check("result", Result, er);
    check("flags", Flags, ef);
    m_result = er;
    m_flags  = ef;
    got_lat  = cyc;
  endtask

  initial begin
    int l;
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_result", Result, 16'h0000);
    check("rst_flags", Flags, 4'h0);
    nReset = 1'b1;

    run_op(5'd2, 16'h7FFF, 16'h0001, l);
    check("add_ovf_lat", l, 1);
    check("add_ovf_res", Result, 16'h8000);
    check("add_ovf_flg", Flags, 4'hC);

    run_op(5'd2, 16'hFFFF, 16'h0001, l);
    check("add_carry_res", Result, 16'h0000);
    check("add_carry_flg", Flags, 4'h3);
    run_op(5'd3, 16'h0001, 16'h0001, l);
    check("adc_res", Result, 16'h0003);
    check("adc_flg", Flags, 4'h0);

    run_op(5'd4, 16'h0005, 16'h0005, l);
    check("sub_eq_res", Result, 16'h0000);
    check("sub_eq_flg", Flags, 4'h3);

    run_op(5'd15, 16'h8004, 16'h0003, l);
    check("asr_lat", l, 4);
    check("asr_res", Result, 16'hF000);
    check("asr_flg", Flags, 4'hA);

    // Reset in cycle 5 of a long LSL abandons it without a Done.
    Func = 5'd13; A = 16'h1234; B = 16'h000F; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    nReset = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_done", Done, 1'b0);
    check("mid_rst_result", Result, 16'h0000);
    check("mid_rst_flags", Flags, 4'h0);
    #1;
    nReset = 1'b1;
    m_result = '0;
    m_flags  = 4'h0;
    run_op(5'd0, 16'hBEEF, 16'h1111, l);
    check("after_rst_lat", l, 1);
    check("after_rst_res", Result, 16'hBEEF);

`ifdef ALU_MUL_EN
    run_op(5'd18, 16'h0100, 16'h0100, l);
    check("mul_lat", l, 17);
    check("mul_res", Result, 16'h0000);
    check("mul_flg", Flags, 4'h3);
`else
    run_op(5'd18, 16'h5A5A, 16'h0100, l);
    check("code18_lat", l, 1);
    check("code18_res", Result, 16'h5A5A);
`endif

    // Shift with k=0 completes immediately with C cleared.
    run_op(5'd14, 16'h8001, 16'hFFF0, l);
    check("lsr_k0_lat", l, 1);

    for (int i = 0; i < 300; i++) begin
      run_op(5'($urandom_range(0, 31)), W'($urandom), W'($urandom), l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
